// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter: default widths, lock states
// and request kinds.
package regfile_pkg;
  localparam int RF_DW = 8;
  localparam int RF_AW = 3;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} lock_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The pointer names the requester that wins the next tie.
// freeze holds the pointer across a grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       freeze,
  output logic [1:0] gnt
);
  logic rr;

  always_comb begin
    gnt = req;
    if (&req) gnt = rr ? 2'b10 : 2'b01;
  end

  // After a grant the pointer moves to the other requester.
  always_ff @(posedge clk or posedge rst)
    if (rst)                   rr <= 1'b0;
    else if (|gnt && !freeze)  rr <= gnt[0];
endmodule

// File: rtl/regfile_arb.sv
// Two-requester arbiter in front of a 2R/1W register file, with round-robin grant.
// Define REGFILE_ARB_LOCK_EN to build the exclusive-access lock FSM.
module regfile_arb
  import regfile_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [2*AW-1:0] req_addr1,
  input  logic [2*AW-1:0] req_addr2,
  input  logic [2*DW-1:0] req_wdata,
  input  logic [1:0]      req_lock,
  output logic [1:0]      resp_valid,
  output logic [DW-1:0]   resp_data1,
  output logic [DW-1:0]   resp_data2,
  output logic            rf_read,
  output logic            rf_write,
  output logic [AW-1:0]   rf_read_port_1,
  output logic [AW-1:0]   rf_read_port_2,
  output logic [AW-1:0]   rf_write_port_1,
  output logic [DW-1:0]   rf_in,
  input  logic [DW-1:0]   rf_out1,
  input  logic [DW-1:0]   rf_out2
);
  logic [1:0] req_eff, gnt;
  logic       freeze;

  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req_eff), .freeze(freeze), .gnt(gnt));

`ifdef REGFILE_ARB_LOCK_EN
  lock_state_e state, state_nxt;

  assign req_eff = (state == LOCK0) ? (req_valid & 2'b01) :
                   (state == LOCK1) ? (req_valid & 2'b10) : req_valid;

  // The pointer stays frozen while locked; the releasing grant updates it.
  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[0] && req_lock[0])      state_nxt = LOCK0;
        else if (gnt[1] && req_lock[1]) state_nxt = LOCK1;
      end
      LOCK0: begin
        freeze = 1'b1;
        if (gnt[0] && !req_lock[0]) begin
          state_nxt = IDLE;
          freeze    = 1'b0;
        end
      end
      LOCK1: begin
        freeze = 1'b1;
        if (gnt[1] && !req_lock[1]) begin
          state_nxt = IDLE;
          freeze    = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign req_eff     = req_valid;
  assign freeze      = 1'b0;
`endif

  logic          sel, we_g;
  logic [AW-1:0] a1_g, a2_g;
  logic [DW-1:0] wd_g;

  assign sel  = gnt[1];
  assign we_g = req_we[sel];
  assign a1_g = sel ? req_addr1[2*AW-1:AW] : req_addr1[AW-1:0];
  assign a2_g = sel ? req_addr2[2*AW-1:AW] : req_addr2[AW-1:0];
  assign wd_g = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

  assign req_ready       = gnt;
  assign rf_read         = (|gnt) && (we_g == REQ_READ);
  assign rf_write        = (|gnt) && (we_g == REQ_WRITE);
  assign rf_read_port_1  = rf_read  ? a1_g : '0;
  assign rf_read_port_2  = rf_read  ? a2_g : '0;
  assign rf_write_port_1 = rf_write ? a1_g : '0;
  assign rf_in           = rf_write ? wd_g : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) resp_valid <= 2'b00;
    else     resp_valid <= rf_read ? gnt : 2'b00;

  // The register file registers its outputs, so read data passes straight through.
  assign resp_data1 = (|resp_valid) ? rf_out1 : '0;
  assign resp_data2 = (|resp_valid) ? rf_out2 : '0;
endmodule

// File: tb/tb_regfile_arb.sv
// Directed bench for regfile_arb with a behavioural registered-output register file.
// Expectations follow REGFILE_ARB_LOCK_EN where the two builds differ.
module tb_regfile_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, req_lock = '0, resp_valid;
  logic [5:0]  req_addr1 = '0, req_addr2 = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0]  resp_data1, resp_data2, rf_in, rf_out1, rf_out2;
  logic        rf_read, rf_write;
  logic [2:0]  rf_read_port_1, rf_read_port_2, rf_write_port_1;

  int errors = 0;
  int checks = 0;

  regfile_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata), .req_lock(req_lock),
    .resp_valid(resp_valid), .resp_data1(resp_data1), .resp_data2(resp_data2),
    .rf_read(rf_read), .rf_write(rf_write), .rf_read_port_1(rf_read_port_1),
    .rf_read_port_2(rf_read_port_2), .rf_write_port_1(rf_write_port_1),
    .rf_in(rf_in), .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  always #5 clk = ~clk;

  // Register file: reg i starts at 8'h10+i; outputs are registered.
  logic [7:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    rf_out1 = '0;
    rf_out2 = '0;
  end
  always @(posedge clk) begin
    if (rf_write) mem[rf_write_port_1] <= rf_in;
    if (rf_read) begin
      rf_out1 <= mem[rf_read_port_1];
      rf_out2 <= mem[rf_read_port_2];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid, we;
    logic [5:0]  a1, a2;
    logic [15:0] wd;
    logic [1:0]  ready;
    logic        rd, wr;
    logic [2:0]  p1, p2, wp;
    logic [7:0]  din;
    logic [1:0]  rv;
    logic [7:0]  d1, d2;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [1:0] exp_g [4];
    logic [2:0] lk;
    int k;

    // {valid, we, addr1, addr2, wdata | ready, rd, wr, p1, p2, wp, din | resp_valid, d1, d2}
    tbl.push_back('{2'b00, 2'b00, 6'd0, 6'd0, 16'h0,  2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00,  2'b00, 8'h00, 8'h00});
    tbl.push_back('{2'b10, 2'b00, {3'd3, 3'd0}, {3'd5, 3'd0}, 16'h0,  2'b10, 1'b1, 1'b0, 3'd3, 3'd5, 3'd0, 8'h00,  2'b00, 8'h00, 8'h00});
    tbl.push_back('{2'b00, 2'b00, 6'd0, 6'd0, 16'h0,  2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00,  2'b10, 8'h13, 8'h15});
    tbl.push_back('{2'b01, 2'b01, {3'd0, 3'd2}, 6'd0, 16'h00A5,  2'b01, 1'b0, 1'b1, 3'd0, 3'd0, 3'd2, 8'hA5,  2'b00, 8'h00, 8'h00});
    tbl.push_back('{2'b10, 2'b00, {3'd2, 3'd0}, 6'd0, 16'h0,  2'b10, 1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 8'h00,  2'b00, 8'h00, 8'h00});
    tbl.push_back('{2'b00, 2'b00, 6'd0, 6'd0, 16'h0,  2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00,  2'b10, 8'hA5, 8'h10});
    tbl.push_back('{2'b11, 2'b00, {3'd6, 3'd1}, {3'd7, 3'd4}, 16'h0,  2'b01, 1'b1, 1'b0, 3'd1, 3'd4, 3'd0, 8'h00,  2'b00, 8'h00, 8'h00});
    tbl.push_back('{2'b11, 2'b00, {3'd6, 3'd1}, {3'd7, 3'd4}, 16'h0,  2'b10, 1'b1, 1'b0, 3'd6, 3'd7, 3'd0, 8'h00,  2'b01, 8'h11, 8'h14});
    tbl.push_back('{2'b11, 2'b00, {3'd6, 3'd1}, {3'd7, 3'd4}, 16'h0,  2'b01, 1'b1, 1'b0, 3'd1, 3'd4, 3'd0, 8'h00,  2'b10, 8'h16, 8'h17});
    tbl.push_back('{2'b11, 2'b00, {3'd6, 3'd1}, {3'd7, 3'd4}, 16'h0,  2'b10, 1'b1, 1'b0, 3'd6, 3'd7, 3'd0, 8'h00,  2'b01, 8'h11, 8'h14});
    tbl.push_back('{2'b00, 2'b00, 6'd0, 6'd0, 16'h0,  2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00,  2'b10, 8'h16, 8'h17});

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", 64'(req_ready), 64'(2'b00));
    chk("reset_outs", 64'({resp_valid, resp_data1, resp_data2, rf_read, rf_write,
                           rf_read_port_1, rf_read_port_2, rf_write_port_1, rf_in}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: drive on the falling edge, sample shortly after
    foreach (tbl[i]) begin
      @(negedge clk);
      req_valid = tbl[i].valid; req_we = tbl[i].we; req_lock = 2'b00;
      req_addr1 = tbl[i].a1; req_addr2 = tbl[i].a2; req_wdata = tbl[i].wd;
      #1;
      chk($sformatf("row%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
      chk($sformatf("row%0d_rf", i),
          64'({rf_read, rf_write, rf_read_port_1, rf_read_port_2, rf_write_port_1, rf_in}),
          64'({tbl[i].rd, tbl[i].wr, tbl[i].p1, tbl[i].p2, tbl[i].wp, tbl[i].din}));
      chk($sformatf("row%0d_resp", i), 64'({resp_valid, resp_data1, resp_data2}),
          64'({tbl[i].rv, tbl[i].d1, tbl[i].d2}));
    end

    // Lock sequence: point rr at requester 1 with a lone grant to 0, then
    // requester 1 issues lock=1,1,0 while requester 0 stays valid.
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_lock = 2'b00; req_addr1 = '0; req_addr2 = '0;
    #1 chk("lock_pre_ready", 64'(req_ready), 64'(2'b01));
`ifdef REGFILE_ARB_LOCK_EN
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b01};
`else
    exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    lk = 3'b011;
    k  = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = {k < 3, 1'b1};
      req_lock  = {(k < 3) ? lk[k] : 1'b0, 1'b0};
      #1 chk($sformatf("lock_seq_c%0d", c), 64'(req_ready), 64'(exp_g[c]));
      if (req_ready[1]) k++;
    end

    // Reset while requester 0 holds a lock with a read response pending
    @(negedge clk);
    req_valid = 2'b00; req_lock = 2'b00;
    @(negedge clk);
    req_valid = 2'b01; req_lock = 2'b01;
    #1 chk("rstlock_grant", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b00; req_lock = 2'b00;
    #1 chk("rstlock_resp_pending", 64'(resp_valid), 64'(2'b01));
    rst = 1'b1;
    #1 chk("rstlock_resp_cleared", 64'({resp_valid, resp_data1, resp_data2}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    #1 chk("rstlock_tie_rr0", 64'(req_ready), 64'(2'b01));
    @(negedge clk);
    req_valid = 2'b10;
    #1 chk("rstlock_fsm_idle", 64'(req_ready), 64'(2'b10));
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("rstlock_resp_after", 64'(resp_valid), 64'(2'b10));
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_arb.md
# regfile_arb

Two-requester arbiter in front of the 8×8-bit register file (`regfile2`: two read ports, one write port). It grants at most one request per cycle and drives the register-file ports from the granted request. It returns read data to the winner one cycle later. Round-robin fairness is the default; optional lock mode gives one requester back-to-back exclusive access for read-modify-write sequences.

## Interface
Parameters:
- `DW`, 8, data width; must match the register file.
- `AW`, 3, register address width (8 registers).

Ports (index i = requester 0/1; packed vectors hold requester 1 in the upper slice):
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  request present, held until accepted.
- `req_ready`  out  2  request accepted this cycle (grant).
- `req_we`  in  2  1 = write, 0 = read.
- `req_addr1`  in  2*AW  read address 1, or the write address when `req_we`=1.
- `req_addr2`  in  2*AW  read address 2 (ignored on writes).
- `req_wdata`  in  2*DW  write data.
- `req_lock`  in  2  request to hold the grant (see Configuration).
- `resp_valid`  out  2  read data valid for requester i.
- `resp_data1`, `resp_data2`  out  DW each  read data, shared by both requesters and qualified by `resp_valid`.
- `rf_read`, `rf_write`  out  1 each  register-file enables.
- `rf_read_port_1`, `rf_read_port_2`, `rf_write_port_1`  out  AW each.
- `rf_in`  out  DW;  `rf_out1`, `rf_out2`  in  DW each.

## Operation
- Grant is combinational from `req_valid`, the round-robin pointer `rr` and the lock state.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by `rr` is granted.
- Handshake: a transfer happens when `req_valid[i]` and `req_ready[i]` are both high.
  - A requester must not drop or change its request before acceptance.
  - `req_ready` never depends on anything the requester computes from `req_ready`.
- Granted read: `rf_read`=1, with ports driven from that requester's `req_addr1`/`req_addr2`.
- Granted write: `rf_write`=1, `rf_write_port_1`=`req_addr1`, `rf_in`=`req_wdata`. No response is returned.
- No grant: `rf_read`=`rf_write`=0 and all address/data outputs are 0.
- `rr` update: after any grant, `rr` points to the other requester. Reset value of `rr` is 0, so requester 0 wins the first tie.
- Lock FSM states: IDLE, LOCK0, LOCK1.
  - IDLE→LOCKi when requester i is granted with `req_lock[i]`=1.
  - In LOCKi, only requester i can be granted. The other requester stalls with `req_ready`=0.
  - LOCKi→IDLE when requester i is granted with `req_lock[i]`=0; that last request still completes.
  - If the owner drops `req_valid`, the lock is held.
  - `rr` is frozen while LOCKi and updates normally on the releasing grant.

## Timing
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `resp_data1`=`resp_data2`=0.
  - All `rf_*` outputs 0, FSM=IDLE, `rr`=0.
- A read accepted in cycle T gives `resp_valid[i]`=1 in cycle T+1 only, for exactly one cycle. `resp_data1`/`resp_data2` carry `rf_out1`/`rf_out2` in that cycle.
- `resp_valid` is registered. The data path passes through combinationally, because the register-file outputs are already registered.
- Throughput is one request per cycle.
  - A write accepted in T is visible to a read accepted in T+1.
  - No forwarding is done within a single cycle, which is impossible anyway since only one request is granted per cycle.
- `rst` asserted mid-lock or mid-response clears FSM, `rr` and `resp_valid` immediately. A response that is in flight is dropped.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined: the lock FSM is built as described above.
- `REGFILE_ARB_LOCK_EN` undefined: no lock FSM. `req_lock` is present but ignored, and arbitration is pure round-robin every cycle. Port list is identical in both builds.

## Structure
- Shared package `regfile_pkg`:
  - `DW`/`AW` defaults.
  - The lock-state enum (IDLE, LOCK0, LOCK1).
  - The request-kind constants (read=0/write=1).
- One natural sub-module: `rr_arb2`, a 2-way round-robin grant with a pointer register and a freeze input. Mux, response register and lock FSM stay in `regfile_arb`.

## Test plan
- Reset then idle: all outputs 0; a single read from requester 1 (addr1=3, addr2=5) gives `req_ready`=2'b10, `rf_read`=1, and `resp_valid`=2'b10 next cycle.
- Requester 0 writes 8'hA5 to reg 2, then requester 1 reads reg 2 on the next cycle: `resp_data1`=8'hA5.
- Both valid continuously with reads: grants alternate 0,1,0,1 starting with 0 after reset, and each `resp_valid` lags its grant by one cycle.
- Lock build: requester 1 issues 3 requests with lock=1,1,0 while requester 0 is valid. Requester 0 is stalled for 3 grants, then granted on the 4th cycle.
- Non-lock build: same stimulus alternates 1,0,1,0 as plain round-robin.
- `rst` pulsed while in LOCK0 with a read response pending: `resp_valid`=0 immediately, FSM=IDLE, and requester 0 wins the next tie.
